// File: rtl/alu_wb_seq.sv
// alu_wb_seq: four-state execute/write-back sequencer
// that owns every control terminal of a 32x32 register file.
module alu_wb_seq (
  input  logic        m_clock,
  input  logic        p_reset,
  input  logic        start,
  input  logic [2:0]  op,
  input  logic [4:0]  rs,
  input  logic [4:0]  rt,
  input  logic [4:0]  rd,
  input  logic [15:0] imm,
  input  logic        use_imm,
  input  logic        clr_req,
  output logic        busy,
  output logic        done,
  output logic [31:0] result,
  output logic        rf_read_a,
  output logic [4:0]  rf_a_addr,
  input  logic [31:0] rf_a,
  output logic        rf_read_b,
  output logic [4:0]  rf_b_addr,
  input  logic [31:0] rf_b,
  output logic        rf_write,
  output logic [4:0]  rf_in_addr,
  output logic [31:0] rf_in,
  output logic        rf_clear
);

  typedef enum logic [1:0] {
    IDLE,
    FETCH,
    EXEC,
    WB
  } state_t;

  state_t      state;
  state_t      state_nx;
  logic [2:0]  op_q;
  logic [4:0]  rs_q;
  logic [4:0]  rt_q;
  logic [4:0]  rd_q;
  logic [15:0] imm_q;
  logic        use_imm_q;
  logic [31:0] a_q;
  logic [31:0] b_q;
  logic [31:0] imm_ext;
  logic [31:0] alu;
  logic        sext;
  logic        accept;

  // clear request outranks a simultaneous start
  assign accept = (state == IDLE) && start && !clr_req;

  always_ff @(posedge m_clock) begin
    if (!p_reset) state <= IDLE;
    else          state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:    if (accept) state_nx = FETCH;
      FETCH:   state_nx = EXEC;
      EXEC:    state_nx = WB;
      WB:      state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge m_clock) begin
    if (accept) begin
      op_q      <= op;
      rs_q      <= rs;
      rt_q      <= rt;
      rd_q      <= rd;
      imm_q     <= imm;
      use_imm_q <= use_imm;
    end
  end

  // arithmetic ops see a signed immediate, logic ops an unsigned one
  assign sext    = (op_q == 3'd0) || (op_q == 3'd1) || (op_q == 3'd5);
  assign imm_ext = sext ? {{16{imm_q[15]}}, imm_q} : {16'd0, imm_q};

  always_ff @(posedge m_clock) begin
    if (state == FETCH) begin
      a_q <= rf_a;
      b_q <= use_imm_q ? imm_ext : rf_b;
    end
  end

  always_comb begin
    alu = 32'd0;
    unique case (op_q)
      3'd0: alu = a_q + b_q;
      3'd1: alu = a_q - b_q;
      3'd2: alu = a_q & b_q;
      3'd3: alu = a_q | b_q;
      3'd4: alu = a_q ^ b_q;
      3'd5: alu = {31'd0, $signed(a_q) < $signed(b_q)};
      3'd6: alu = a_q << b_q[4:0];
      3'd7: alu = a_q >> b_q[4:0];
      default: alu = 32'd0;
    endcase
  end

  always_ff @(posedge m_clock) begin
    if (!p_reset)           result <= 32'd0;
    else if (state == EXEC) result <= alu;
  end

  always_comb begin
    busy       = (state != IDLE);
    done       = (state == WB);
    rf_read_a  = (state == FETCH);
    rf_a_addr  = rf_read_a ? rs_q : 5'd0;
    rf_read_b  = (state == FETCH) && !use_imm_q;
    rf_b_addr  = rf_read_b ? rt_q : 5'd0;
    rf_write   = (state == WB) && (rd_q != 5'd0);
    rf_in_addr = rf_write ? rd_q : 5'd0;
    rf_in      = rf_write ? result : 32'd0;
    rf_clear   = (state == IDLE) && clr_req && p_reset;
  end

endmodule

// File: tb/tb_alu_wb_seq.sv
// tb_alu_wb_seq: register-file model, cycle schedule model
// and directed vectors for alu_wb_seq.
module tb_alu_wb_seq;

  logic        clk;
  logic        p_reset;
  logic        start;
  logic [2:0]  op;
  logic [4:0]  rs;
  logic [4:0]  rt;
  logic [4:0]  rd;
  logic [15:0] imm;
  logic        use_imm;
  logic        clr_req;
  logic        busy;
  logic        done;
  logic [31:0] result;
  logic        rf_read_a;
  logic [4:0]  rf_a_addr;
  logic [31:0] rf_a;
  logic        rf_read_b;
  logic [4:0]  rf_b_addr;
  logic [31:0] rf_b;
  logic        rf_write;
  logic [4:0]  rf_in_addr;
  logic [31:0] rf_in;
  logic        rf_clear;

  int checks = 0;
  int failures = 0;

  alu_wb_seq dut (
    .m_clock    (clk),
    .p_reset    (p_reset),
    .start      (start),
    .op         (op),
    .rs         (rs),
    .rt         (rt),
    .rd         (rd),
    .imm        (imm),
    .use_imm    (use_imm),
    .clr_req    (clr_req),
    .busy       (busy),
    .done       (done),
    .result     (result),
    .rf_read_a  (rf_read_a),
    .rf_a_addr  (rf_a_addr),
    .rf_a       (rf_a),
    .rf_read_b  (rf_read_b),
    .rf_b_addr  (rf_b_addr),
    .rf_b       (rf_b),
    .rf_write   (rf_write),
    .rf_in_addr (rf_in_addr),
    .rf_in      (rf_in),
    .rf_clear   (rf_clear)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // register file model
  logic [31:0] rf [32];
  logic        pl_en = 1'b0;
  logic [4:0]  pl_addr = 5'd0;
  logic [31:0] pl_data = 32'd0;

  assign rf_a = (rf_a_addr == 5'd0) ? 32'd0 : rf[rf_a_addr];
  assign rf_b = (rf_b_addr == 5'd0) ? 32'd0 : rf[rf_b_addr];

  always @(posedge clk) begin
    if (rf_clear) begin
      for (int i = 0; i < 32; i++) rf[i] <= 32'd0;
    end else if (rf_write && rf_in_addr != 5'd0) begin
      rf[rf_in_addr] <= rf_in;
    end else if (pl_en) begin
      rf[pl_addr] <= pl_data;
    end
  end

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", nm, act, exp);
    end
  endtask

  function automatic logic [31:0] golden(input logic [2:0] o,
                                         input logic [31:0] a,
                                         input logic [31:0] b);
    logic [31:0] r;
    case (o)
      3'd0: r = a + b;
      3'd1: r = a - b;
      3'd2: r = a & b;
      3'd3: r = a | b;
      3'd4: r = a ^ b;
      3'd5: r = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      3'd6: r = a << b[4:0];
      default: r = a >> b[4:0];
    endcase
    return r;
  endfunction

  // schedule model: an instruction accepted in cycle t is k=cyc-t cycles old
  int          cyc = 0;
  int          acc = -1;
  logic        chk_en = 1'b0;
  logic [2:0]  m_op;
  logic [4:0]  m_rs, m_rt, m_rd;
  logic [15:0] m_imm;
  logic        m_ui;
  logic [31:0] m_pend = 32'd0;
  logic [31:0] m_res = 32'd0;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (chk_en) begin
      int k;
      logic [31:0] a, b;
      logic wr;
      k  = (acc >= 0) ? cyc - acc : 0;
      wr = (k == 3) && (m_rd != 5'd0);
      chk("busy", {31'd0, busy}, {31'd0, k >= 1 && k <= 3});
      chk("done", {31'd0, done}, {31'd0, k == 3});
      chk("result", result, m_res);
      chk("rf_read_a", {31'd0, rf_read_a}, {31'd0, k == 1});
      chk("rf_a_addr", {27'd0, rf_a_addr}, (k == 1) ? {27'd0, m_rs} : 32'd0);
      chk("rf_read_b", {31'd0, rf_read_b}, {31'd0, k == 1 && !m_ui});
      chk("rf_b_addr", {27'd0, rf_b_addr},
          (k == 1 && !m_ui) ? {27'd0, m_rt} : 32'd0);
      chk("rf_write", {31'd0, rf_write}, {31'd0, wr});
      chk("rf_in_addr", {27'd0, rf_in_addr}, wr ? {27'd0, m_rd} : 32'd0);
      chk("rf_in", rf_in, wr ? m_pend : 32'd0);
      chk("rf_clear", {31'd0, rf_clear},
          {31'd0, k == 0 && clr_req && p_reset});
      if (k == 1) begin
        a = (m_rs == 5'd0) ? 32'd0 : rf[m_rs];
        if (m_ui)
          b = (m_op == 3'd0 || m_op == 3'd1 || m_op == 3'd5)
              ? {{16{m_imm[15]}}, m_imm} : {16'd0, m_imm};
        else
          b = (m_rt == 5'd0) ? 32'd0 : rf[m_rt];
        m_pend = golden(m_op, a, b);
      end
      if (!p_reset) begin
        acc   = -1;
        m_res = 32'd0;
      end else begin
        if (k == 2) m_res = m_pend;
        if (k == 3) acc = -1;
        if (k == 0 && !clr_req && start) begin
          acc   = cyc;
          m_op  = op;
          m_rs  = rs;
          m_rt  = rt;
          m_rd  = rd;
          m_imm = imm;
          m_ui  = use_imm;
        end
      end
    end
  end

  task automatic preload(input logic [4:0] ad, input logic [31:0] d);
    @(posedge clk); #1;
    pl_en = 1'b1; pl_addr = ad; pl_data = d;
    @(posedge clk); #1;
    pl_en = 1'b0;
  endtask

  task automatic run(input string nm, input logic [2:0] o,
                     input logic [4:0] s, input logic [4:0] t,
                     input logic [4:0] d, input logic [15:0] im,
                     input logic ui, input logic [31:0] exp);
    int n;
    @(posedge clk); #1;
    op = o; rs = s; rt = t; rd = d; imm = im; use_imm = ui; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!done && n < 8);
    chk({nm, " done_latency"}, n, 3);
    chk({nm, " result"}, result, exp);
    chk({nm, " rf_in"}, rf_in, (d == 5'd0) ? 32'd0 : exp);
    @(posedge clk); #1;
    if (d != 5'd0) chk({nm, " rf_readback"}, rf[d], exp);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end

  initial begin
    int dn, wr;
    p_reset = 1'b0; start = 1'b1; clr_req = 1'b0;
    op = 3'd0; rs = 5'd0; rt = 5'd0; rd = 5'd0; imm = 16'd0; use_imm = 1'b0;
    @(posedge clk); #1;
    chk_en = 1'b1;
    @(negedge clk);
    chk("rst busy", {31'd0, busy}, 32'd0);
    chk("rst done", {31'd0, done}, 32'd0);
    chk("rst result", result, 32'd0);
    chk("rst strobes",
        {28'd0, rf_read_a, rf_read_b, rf_write, rf_clear}, 32'd0);
    @(posedge clk); #1;
    start = 1'b0; p_reset = 1'b1;

    // zero the file
    clr_req = 1'b1;
    @(posedge clk); #1;
    clr_req = 1'b0;

    preload(5'd1, 32'd7);
    preload(5'd2, 32'hFFFF_FFFF);
    run("add_wrap", 3'd0, 5'd1, 5'd2, 5'd3, 16'd0, 1'b0, 32'd6);

    preload(5'd1, 32'd5);
    run("addi_sext", 3'd0, 5'd1, 5'd0, 5'd6, 16'hFFFF, 1'b1, 32'd4);
    run("ori_zext", 3'd3, 5'd1, 5'd0, 5'd7, 16'hFFFF, 1'b1, 32'h0000_FFFF);
    run("slti_neg", 3'd5, 5'd1, 5'd0, 5'd8, 16'h8000, 1'b1, 32'd0);
    run("sub", 3'd1, 5'd1, 5'd2, 5'd9, 16'd0, 1'b0, 32'd6);
    run("xor", 3'd4, 5'd1, 5'd2, 5'd10, 16'd0, 1'b0, 32'hFFFF_FFFA);

    preload(5'd4, 32'h8000_0001);
    run("srli", 3'd7, 5'd4, 5'd0, 5'd11, 16'd4, 1'b1, 32'h0800_0000);
    run("slli", 3'd6, 5'd4, 5'd0, 5'd12, 16'd31, 1'b1, 32'h8000_0000);
    run("slt", 3'd5, 5'd4, 5'd1, 5'd13, 16'd0, 1'b0, 32'd1);
    run("andi_zext", 3'd2, 5'd4, 5'd0, 5'd14, 16'hFFFF, 1'b1, 32'd1);

    // rd=0 plus a start pulse while busy
    @(posedge clk); #1;
    op = 3'd0; rs = 5'd1; rt = 5'd2; rd = 5'd0; use_imm = 1'b0; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    @(posedge clk); #1;
    start = 1'b1; rd = 5'd15;
    @(posedge clk); #1;
    start = 1'b0;
    dn = 0; wr = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (done) dn++;
      if (rf_write) wr++;
    end
    chk("rd0 done_count", dn, 1);
    chk("rd0 write_count", wr, 0);
    chk("busy_ignore r15", rf[15], 32'd0);

    // clear outranks start
    @(posedge clk); #1;
    clr_req = 1'b1; start = 1'b1; op = 3'd0; rs = 5'd1; rd = 5'd16;
    @(negedge clk);
    chk("clr strobe", {31'd0, rf_clear}, 32'd1);
    chk("clr busy", {31'd0, busy}, 32'd0);
    @(posedge clk); #1;
    clr_req = 1'b0; start = 1'b0;
    chk("clr r3", rf[3], 32'd0);
    @(negedge clk);
    chk("clr dropped", {31'd0, busy}, 32'd0);

    // reset during EXEC aborts the instruction
    preload(5'd1, 32'd9);
    @(posedge clk); #1;
    op = 3'd0; rs = 5'd1; rt = 5'd1; rd = 5'd17; use_imm = 1'b0; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    @(posedge clk); #1;
    p_reset = 1'b0;
    @(posedge clk); #1;
    p_reset = 1'b1;
    dn = 0; wr = 0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      if (done) dn++;
      if (rf_write) wr++;
    end
    chk("abort done_count", dn, 0);
    chk("abort write_count", wr, 0);
    chk("abort busy", {31'd0, busy}, 32'd0);
    chk("abort result", result, 32'd0);
    chk("abort r17", rf[17], 32'd0);

    @(posedge clk); #1;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
